// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle MUL/DIVU/REMU sequencer and the
// execute-stage ALU it drives.
package alu_pkg;

  // ALU operation codes understood by the 32-bit execute-stage ALU
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  // The ALU is fixed at this width
  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL     = 2'b00,
    OP_DIVU    = 2'b01,
    OP_REMU    = 2'b10,
    OP_ILLEGAL = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_STEP = 3'd1,
    ST_DIV_CMP  = 3'd2,
    ST_DIV_SUB  = 3'd3,
    ST_FINISH   = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle sequencer for MUL (shift-add, 32 steps) and DIVU/REMU
// (restoring division, compare + subtract per bit) that borrows the
// execute-stage ALU for every add, subtract and compare.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_resultado,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t   state;
  muldiv_op_t      op_reg;
  logic [4:0]      cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] d;
  logic            lt;
  logic [XLEN-1:0] rs;
  muldiv_op_t      op_in;

  assign op_in = muldiv_op_t'(op);

  // Shifted partial remainder; the bit shifted out of rem[31] is tracked
  // separately through the forced-subtract term in DIV_CMP.
  assign rs = {rem[XLEN-2:0], q[XLEN-1]};

  // ALU operands come straight from the state registers so the ALU result
  // is available to the FSM within the same cycle.
  always_comb begin
    alu_x       = '0;
    alu_y       = '0;
    alu_control = ALU_ADD;
    case (state)
      ST_MUL_STEP: begin
        alu_x       = acc;
        alu_y       = mcand;
        alu_control = ALU_ADD;
      end
      ST_DIV_CMP: begin
        alu_x       = rs;
        alu_y       = d;
        alu_control = ALU_SLTU;
      end
      ST_DIV_SUB: begin
        if (!lt) begin
          alu_x       = rem;
          alu_y       = d;
          alu_control = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with its datapath registers and registered handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_reg <= OP_MUL;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      q      <= '0;
      d      <= '0;
      lt     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_reg <= op_in;
            cnt    <= '0;
            busy   <= 1'b1;
            case (op_in)
              OP_MUL: begin
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                state  <= ST_MUL_STEP;
              end
              OP_DIVU, OP_REMU: begin
                if (b != '0) begin
                  rem   <= '0;
                  q     <= a;
                  d     <= b;
                  state <= ST_DIV_CMP;
                end else begin
                  // Divide by zero: all-ones quotient, dividend as remainder
                  result <= (op_in == OP_DIVU) ? '1 : a;
                  done   <= 1'b1;
                  state  <= ST_FINISH;
                end
              end
              default: begin
                result <= '0;
                done   <= 1'b1;
                state  <= ST_FINISH;
              end
            endcase
          end
        end
        ST_MUL_STEP: begin
          if (mplier[0]) acc <= alu_resultado;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            // Result is loaded with the final accumulator so it lines up with DONE
            result <= mplier[0] ? alu_resultado : acc;
            done   <= 1'b1;
            state  <= ST_FINISH;
          end
        end
        ST_DIV_CMP: begin
          rem   <= rs;
          q     <= {q[XLEN-2:0], 1'b0};
          lt    <= alu_resultado[0] & ~rem[XLEN-1];
          state <= ST_DIV_SUB;
        end
        ST_DIV_SUB: begin
          if (!lt) begin
            rem  <= alu_resultado;
            q[0] <= 1'b1;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (op_reg == OP_DIVU) result <= {q[XLEN-1:1], q[0] | ~lt};
            else                   result <= lt ? rem : alu_resultado;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            state <= ST_DIV_CMP;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs RV32M MUL, DIVU and REMU by driving the existing 32-bit ALU one operation per cycle.
- MUL uses shift-add; DIVU/REMU use restoring division.
- Sits beside the execute stage and owns the ALU operand/control inputs while BUSY.
- The control unit starts an operation with a START/BUSY/DONE handshake.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, because the ALU is fixed at 32 bits.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
START  in  1  request; sampled only in IDLE
OP  in  2  00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 illegal
A  in  32  multiplicand / dividend
B  in  32  multiplier / divisor
ALU_X  out  32  ALU operand X
ALU_Y  out  32  ALU operand Y
ALU_CONTROL  out  4  ALU operation code
ALU_RESULTADO  in  32  ALU combinational result
BUSY  out  1  operation in progress
DONE  out  1  one-cycle pulse; RESULT valid
RESULT  out  32  product, quotient or remainder; holds until next DONE

Behaviour:
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-high.
- Reset values: state IDLE; BUSY=0, DONE=0, RESULT=0, ALU_X=0, ALU_Y=0, ALU_CONTROL=0000; all internal registers 0.
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, FINISH. Internal step counter cnt is 5 bits.
- IDLE, START=1 with OP=00:
  - acc=0, mcand=A, mplier=B, cnt=0.
  - Next state MUL_STEP.
- MUL_STEP, every cycle:
  - Drive ALU_X=acc, ALU_Y=mcand, ALU_CONTROL=0000 (ADD).
  - If mplier[0]=1, acc<=ALU_RESULTADO.
  - mcand<<=1; mplier>>=1; cnt++.
  - After cnt=31, go to FINISH. Always 32 steps; no early exit.
- IDLE, START=1 with OP=01/10 and B!=0:
  - rem=0, q=A, d=B, cnt=0.
  - Next state DIV_CMP.
- DIV_CMP:
  - rs={rem[30:0],q[31]}.
  - Drive ALU_X=rs, ALU_Y=d, ALU_CONTROL=1101 (unsigned less-than).
  - rem<=rs; q<={q[30:0],1'b0}.
  - lt<=ALU_RESULTADO[0] & ~rem[31]. If rem[31] was 1, rs is at least 2^32 and subtraction is forced.
  - Next state DIV_SUB.
- DIV_SUB:
  - If lt=0: drive ALU_X=rem, ALU_Y=d, ALU_CONTROL=0111 (SUB); rem<=ALU_RESULTADO; q[0]<=1.
  - If lt=1: drive the ALU outputs to 0/0/0000 and leave rem and q unchanged.
  - cnt++. After cnt=31 go to FINISH, else go to DIV_CMP.
- Divide by zero (OP=01/10, B=0):
  - Go directly to FINISH.
  - Quotient=32'hFFFFFFFF, remainder=A (RISC-V semantics).
- Illegal OP=11: go directly to FINISH with RESULT=0.
- FINISH:
  - DONE=1 for exactly one cycle.
  - RESULT<=acc (MUL), q (DIVU) or rem (REMU); RESULT is registered, so DONE and RESULT are valid in the same cycle.
  - Next state IDLE.
- BUSY=1 in every state except IDLE.
- ALU outputs are 0/0/0000 in IDLE and FINISH.
- Latency from the START-accepted edge to the DONE cycle:
  - MUL: 33 cycles.
  - DIVU/REMU: 65 cycles.
  - Divide by zero or illegal OP: 1 cycle.
- START while BUSY (including in FINISH) is ignored; it is not queued. A, B and OP are latched only at acceptance.
- RST asserted mid-operation: immediate return to IDLE; no DONE pulse; RESULT is cleared to 0.
- All arithmetic is modulo 2^32. Carry-out is discarded on MUL accumulation.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants: ADD 0000, SUB 0111, SLTU 1101, plus the rest of the ALU code set.
  - muldiv_op_t enum for OP encoding.
  - muldiv_state_t enum for the FSM states.
- No sub-module: the FSM and shift registers form one module. The ALU is instantiated outside, at the execute stage, with a mux selecting this block's operands while BUSY=1.

Test Plan:
1. MUL A=7, B=6 -> DONE exactly 33 cycles after START, RESULT=42; BUSY high for cycles 1..33.
2. MUL A=32'hFFFFFFFF, B=32'hFFFFFFFF -> RESULT=32'h00000001; also MUL A=32'h12345678, B=0 -> RESULT=0, still 33-cycle latency.
3. DIVU A=100, B=7 -> RESULT=14 at cycle 65; REMU same operands -> RESULT=2; ALU_CONTROL alternates 1101/0111 during the operation.
4. DIVU A=32'hFFFFFFFF, B=32'h80000001 -> RESULT=1; REMU same operands -> RESULT=32'h7FFFFFFE (exercises the rem[31] forced-subtract path).
5. DIVU A=5, B=0 -> DONE 1 cycle later, RESULT=32'hFFFFFFFF; REMU -> RESULT=5; OP=11 -> DONE 1 cycle later, RESULT=0.
6. START pulses at cycles 5 and 20 of a MUL are ignored and RESULT is for the first operands; RST asserted at step 10 of a DIVU -> BUSY=0, DONE=0, RESULT=0 immediately; a new MUL 3×3 afterwards -> RESULT=9.
